// File: rtl/bit_serial_add_seq.sv
// Bit-serial adder sequencer: one fa cell, LSB first, WIDTH+1-bit result over valid/ready.
// Optional subtract mode is enabled by defining BSADD_SUB_EN.

module fa (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  logic s_raw;
  logic c_raw;

  assign s_raw = a ^ b ^ c_in;
  assign c_raw = (a & b) | (a & c_in) | (b & c_in);

  // Stuck-output fault hooks; the sequencer passes their effect straight through.
`ifdef FA_SR_S_STUCK0
  assign s = 1'b0;
`elsif FA_SR_S_STUCK1
  assign s = 1'b1;
`else
  assign s = s_raw;
`endif

`ifdef FA_SR_COUT_STUCK0
  assign c_out = 1'b0;
`elsif FA_SR_COUT_STUCK1
  assign c_out = 1'b1;
`else
  assign c_out = c_raw;
`endif
endmodule

module bit_serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef BSADD_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH:0]     out_sum_q, out_sum_d;
  logic               fa_b;
  logic               fa_s;
  logic               fa_c;
  logic               carry_init;

`ifdef BSADD_SUB_EN
  logic sub_q, sub_d;
  // Subtract as a + ~b + 1: invert b into the cell and seed the carry with 1.
  assign fa_b       = b_sh_q[0] ^ sub_q;
  assign carry_init = in_sub;
`else
  assign fa_b       = b_sh_q[0];
  assign carry_init = 1'b0;
`endif

  fa u_fa (
    .a     (a_sh_q[0]),
    .b     (fa_b),
    .c_in  (carry_q),
    .s     (fa_s),
    .c_out (fa_c)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = out_sum_q;

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    out_sum_d = out_sum_q;
`ifdef BSADD_SUB_EN
    sub_d     = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d   = in_a;
          b_sh_d   = in_b;
          sum_sh_d = '0;
          cnt_d    = '0;
          carry_d  = carry_init;
`ifdef BSADD_SUB_EN
          sub_d    = in_sub;
`endif
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_c;
        cnt_d    = cnt_q + CNT_W'(1);
        // Final bit: splice the live s/c_out onto the WIDTH-1 bits already collected.
        if (cnt_q == LAST_CNT) begin
          out_sum_d = {fa_c, fa_s, sum_sh_q[WIDTH-1:1]};
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_sh_q  <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      out_sum_q <= '0;
`ifdef BSADD_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      sum_sh_q  <= sum_sh_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      out_sum_q <= out_sum_d;
`ifdef BSADD_SUB_EN
      sub_q     <= sub_d;
`endif
    end
  end
endmodule
